// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One iteration per clock: shift-add for multiply, restoring shift-subtract for divide.
module mul_div_unit #(
  parameter int SIZEDATA = 32,
  parameter int SIZEOP   = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [SIZEOP-1:0]   i_mduop,
  input  logic [SIZEDATA-1:0] i_datoa,
  input  logic [SIZEDATA-1:0] i_datob,
  output logic [SIZEDATA-1:0] o_hi,
  output logic [SIZEDATA-1:0] o_lo,
  output logic                o_busy,
  output logic                o_done
);

  // state | meaning
  // IDLE  | waiting for i_start; MTHI/MTLO handled here
  // CALC  | one multiply/divide iteration per cycle, SIZEDATA cycles
  // DONE  | o_done pulse, results valid in HI/LO
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int N  = SIZEDATA;
  localparam int CW = $clog2(SIZEDATA);

  localparam logic [SIZEOP-1:0] OP_MTHI = SIZEOP'(4);
  localparam logic [SIZEOP-1:0] OP_MTLO = SIZEOP'(5);

  state_t state, state_nxt;

  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [N-1:0]   opnd_q;
  logic [N-1:0]   a_q;
  logic           is_div_q;
  logic           sa_q, sb_q;
  logic           b_zero_q;
  logic [N-1:0]   hi_q, lo_q;

  logic           start_calc;
  logic           signed_op;
  logic           sa, sb;
  logic [N-1:0]   mag_a, mag_b;
  logic           last_iter;

  logic [N:0]     mul_sum;
  logic [N:0]     div_shift;
  logic           div_ge;
  logic [N-1:0]   div_sub;
  logic [2*N-1:0] acc_nxt;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo, rem;
  logic [N-1:0]   res_hi, res_lo;

  assign start_calc = (state == IDLE) && i_start && (i_mduop < OP_MTHI);
  // MULT (000) and DIV (010) are the signed forms
  assign signed_op  = ~i_mduop[0];
  assign sa         = signed_op & i_datoa[N-1];
  assign sb         = signed_op & i_datob[N-1];
  assign mag_a      = sa ? -i_datoa : i_datoa;
  assign mag_b      = sb ? -i_datob : i_datob;
  assign last_iter  = (cnt == CW'(N-1));

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_calc) state_nxt = CALC;
      CALC: if (last_iter)  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);
  assign o_done = (state == DONE);

  // Datapath step: acc holds {partial product} for multiply, {remainder, quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc[2*N-1:N-1];
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_sub   = div_shift[N-1:0] - opnd_q;
    if (is_div_q)
      acc_nxt = {(div_ge ? div_sub : div_shift[N-1:0]), acc[N-2:0], div_ge};
    else
      acc_nxt = {mul_sum, acc[N-1:1]};
  end

  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc_nxt : acc_nxt;
    quo  = (sa_q ^ sb_q) ? -acc_nxt[N-1:0] : acc_nxt[N-1:0];
    rem  = sa_q ? -acc_nxt[2*N-1:N] : acc_nxt[2*N-1:N];
    if (!is_div_q) begin
      res_hi = prod[2*N-1:N];
      res_lo = prod[N-1:0];
    end else if (b_zero_q) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_calc) begin
            cnt      <= '0;
            is_div_q <= i_mduop[1];
            sa_q     <= sa;
            sb_q     <= sb;
            a_q      <= i_datoa;
            b_zero_q <= (i_datob == '0);
            acc      <= {{N{1'b0}}, (i_mduop[1] ? mag_a : mag_b)};
            opnd_q   <= i_mduop[1] ? mag_b : mag_a;
          end else if (i_start && i_mduop == OP_MTHI) begin
            hi_q <= i_datoa;
          end else if (i_start && i_mduop == OP_MTLO) begin
            lo_q <= i_datoa;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hi = hi_q;
  assign o_lo = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at SIZEDATA=32.
// Vector table for single operations plus hand sequences for multi-cycle corners.
module tb_mul_div_unit;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;
  localparam logic [2:0] RSVD  = 3'b110;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [2:0]  i_mduop;
  logic [31:0] i_datoa, i_datob;
  logic [31:0] o_hi, o_lo;
  logic        o_busy, o_done;

  int tests_run = 0;
  int tests_failed = 0;

  mul_div_unit #(.SIZEDATA(32), .SIZEOP(3)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_mduop(i_mduop),
    .i_datoa(i_datoa),
    .i_datob(i_datob),
    .o_hi   (o_hi),
    .o_lo   (o_lo),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; issues the op, scrambles the inputs after the accept
  // edge, and returns at the negedge after the DONE cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    bit busy_ok;
    i_mduop = op; i_datoa = a; i_datob = b; i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0; i_datoa = ~a; i_datob = ~b;
    n = 1;
    busy_ok = 1'b1;
    while (!o_done && n < 40) begin
      if (!o_busy) busy_ok = 1'b0;
      @(negedge i_clk);
      n++;
    end
    check({name, " latency"}, 64'(n), 64'd33);
    check({name, " busy"}, {63'd0, busy_ok & o_busy}, 64'd1);
    check({name, " hi"}, {32'd0, o_hi}, {32'd0, exp_hi});
    check({name, " lo"}, {32'd0, o_lo}, {32'd0, exp_lo});
    @(negedge i_clk);
  endtask

  initial begin
    int n;
    int done_seen;
    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5]  = '{DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[6]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7]  = '{MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
    vecs[8]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9]  = '{MULT,  32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[10] = '{DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
    vecs[12] = '{MULTU, 32'd0,        32'h12345,    32'd0,        32'd0};

    i_reset = 1'b1; i_start = 1'b0; i_mduop = MULT; i_datoa = '0; i_datob = '0;
    repeat (3) @(negedge i_clk);
    check("reset hi",   {32'd0, o_hi}, 64'd0);
    check("reset lo",   {32'd0, o_lo}, 64'd0);
    check("reset busy", {63'd0, o_busy}, 64'd0);
    check("reset done", {63'd0, o_done}, 64'd0);
    i_reset = 1'b0;

    // First op issued in the very first cycle after reset release
    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MTHI / reserved op / MTLO in IDLE
    i_mduop = MTHI; i_datoa = 32'hABCD0001; i_start = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_start = 1'b0;
    check("mthi hi",   {32'd0, o_hi}, 64'hABCD0001);
    check("mthi lo",   {32'd0, o_lo}, 64'd0);
    check("mthi busy", {62'd0, o_busy, o_done}, 64'd0);
    i_mduop = RSVD; i_datoa = 32'h5555AAAA; i_start = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_start = 1'b0;
    check("rsvd hi",   {32'd0, o_hi}, 64'hABCD0001);
    check("rsvd lo",   {32'd0, o_lo}, 64'd0);
    check("rsvd busy", {62'd0, o_busy, o_done}, 64'd0);

    // DIVU 9/4 with a MULT start pulsed mid-CALC, then MTLO right after DONE
    i_mduop = DIVU; i_datoa = 32'd9; i_datob = 32'd4; i_start = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_start = 1'b0;
    n = 1;
    while (!o_done && n < 40) begin
      if (n == 5) begin
        i_mduop = MULT; i_datoa = 32'd2; i_datob = 32'd3; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
      n++;
    end
    i_start = 1'b0;
    check("ignore latency", 64'(n), 64'd33);
    check("ignore hi", {32'd0, o_hi}, 64'd1);
    check("ignore lo", {32'd0, o_lo}, 64'd2);
    @(negedge i_clk);
    i_mduop = MTLO; i_datoa = 32'h1234; i_start = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_start = 1'b0;
    check("mtlo lo",   {32'd0, o_lo}, 64'h1234);
    check("mtlo hi",   {32'd0, o_hi}, 64'd1);
    check("mtlo busy", {62'd0, o_busy, o_done}, 64'd0);

    // Reset on CALC cycle 10 abandons the op
    i_mduop = MULTU; i_datoa = 32'd1000; i_datob = 32'd1000; i_start = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge i_clk);
    check("calc10 busy", {63'd0, o_busy}, 64'd1);
    i_reset = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_reset = 1'b0;
    check("abort busy", {63'd0, o_busy}, 64'd0);
    check("abort hi",   {32'd0, o_hi}, 64'd0);
    check("abort lo",   {32'd0, o_lo}, 64'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_done) done_seen++;
      @(negedge i_clk);
    end
    check("abort no done", 64'(done_seen), 64'd0);

    // Reset wins over a simultaneous start
    i_reset = 1'b1; i_mduop = MULTU; i_datoa = 32'd3; i_datob = 32'd3; i_start = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    check("reset prio busy", {63'd0, o_busy}, 64'd0);
    i_reset = 1'b0;
    run_op("post reset", MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
    run_op("back2back", DIVU, 32'd15, 32'd4, 32'd3, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
